vga_timing_gen: RTL and testbench

Pixel-timing generator for the 640x480@60 Hz display path. It drives the per-pixel `DrawX`/`DrawY`/`blank` consumed by the sprite ROM/palette drawing stages, plus active-low sync. It also provides sync/blank copies delayed to line up with those stages' registered RGB outputs, and frame/line strobes and a frame counter for game-logic and animation timing.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_sync_delay.sv | 31 +++
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and the sync/blank bundle used by
// the timing generator and the drawing stages.
package vga_pkg;
    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_SYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    // Idle level of the connector-side signals: syncs deasserted, display blanked.
    localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// Parameterized-depth shift register with per-bit reset value; depth 0 is a
// plain wire so the connector signals can track the undelayed ones.
module vga_sync_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             gclk,
    input  logic             grst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] sr;

            always_ff @(posedge gclk or negedge grst_n) begin
                if (!grst_n) begin
                    sr <= {DEPTH{RST_VAL}};
                end else begin
                    sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign q = sr[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// Free-running 640x480 pixel timing: H/V counters, registered sync/blank/strobe
// decode, frame counter, and sync/blank copies delayed to match the RGB pipeline.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam cnt_t H_MAX = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_MAX = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_VIS = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_LO = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_HI = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t VS_LO = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_HI = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    cnt_t  h_cnt, v_cnt, h_nxt, v_nxt;
    logic  h_wrap;
    sync_t sync_now, sync_dly;

    always_comb begin
        h_wrap = (h_cnt == H_MAX);
        h_nxt  = h_wrap ? '0 : h_cnt + cnt_t'(1);
        v_nxt  = v_cnt;
        if (h_wrap) v_nxt = (v_cnt == V_MAX) ? '0 : v_cnt + cnt_t'(1);
    end

    // Decode from the next count so each flag lands with its DrawX/DrawY.
    // Reset parks the counters on the last pixel so the first edge yields (0,0).
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= H_MAX;
            v_cnt       <= V_MAX;
            blank       <= 1'b0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            blank       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hs          <= !in_window(h_nxt, HS_LO, HS_HI);
            vs          <= !in_window(v_nxt, VS_LO, VS_HI);
            line_start  <= (h_nxt == '0);
            frame_start <= (h_nxt == '0) && (v_nxt == '0);
            if ((h_nxt == '0) && (v_nxt == '0)) frame_count <= frame_count + 8'd1;
        end
    end

    assign DrawX    = h_cnt;
    assign DrawY    = v_cnt;
    assign sync_now = '{hs: hs, vs: vs, blank: blank};

    vga_sync_delay #(
        .DEPTH  (PIPE_DELAY),
        .WIDTH  ($bits(sync_t)),
        .RST_VAL(SYNC_RST)
    ) u_sync_delay (
        .gclk  (vga_clk),
        .grst_n(reset_n),
        .d     (sync_now),
        .q     (sync_dly)
    );

    assign hs_d    = sync_dly.hs;
    assign vs_d    = sync_dly.vs;
    assign blank_d = sync_dly.blank;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (delay 2) and a shrunken-timing
// instance (delay 0) checked every cycle against an arithmetic timing model.
module tb_vga_timing_gen;
    typedef struct {
        int hv, hf, hsy, hb, vv, vf, vsy, vb, d;
    } tim_t;

    typedef struct {
        int x, y, blank, hs, vs, ls, fs, fc;
    } exp_t;

    localparam tim_t TA = '{hv: 640, hf: 16, hsy: 96, hb: 48, vv: 480, vf: 10, vsy: 2, vb: 33, d: 2};
    localparam tim_t TB = '{hv: 8, hf: 2, hsy: 3, hb: 3, vv: 6, vf: 1, vsy: 2, vb: 2, d: 0};
    localparam int B_FRAME = 16 * 11;

    logic clk = 1'b0;
    logic rst_a = 1'b0, rst_b = 1'b0;
    int   errors = 0, checks = 0;
    int   k_a, k_b;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic [7:0] fc_a, fc_b;
    logic bl_a, hs_a, vs_a, hsd_a, vsd_a, bld_a, ls_a, fs_a;
    logic bl_b, hs_b, vs_b, hsd_b, vsd_b, bld_b, ls_b, fs_b;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .vga_clk(clk), .reset_n(rst_a), .DrawX(x_a), .DrawY(y_a), .blank(bl_a),
        .hs(hs_a), .vs(vs_a), .hs_d(hsd_a), .vs_d(vsd_a), .blank_d(bld_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .PIPE_DELAY(0)
    ) dut_b (
        .vga_clk(clk), .reset_n(rst_b), .DrawX(x_b), .DrawY(y_b), .blank(bl_b),
        .hs(hs_b), .vs(vs_b), .hs_d(hsd_b), .vs_d(vsd_b), .blank_d(bld_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    // k = rising edges since reset released; -1 while still at reset values.
    always @(posedge clk or negedge rst_a) if (!rst_a) k_a <= -1; else k_a <= k_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) k_b <= -1; else k_b <= k_b + 1;

    function automatic exp_t model(tim_t t, int k);
        exp_t e;
        int ht, vt, hs0, vs0;
        ht  = t.hv + t.hf + t.hsy + t.hb;
        vt  = t.vv + t.vf + t.vsy + t.vb;
        hs0 = t.hv + t.hf;
        vs0 = t.vv + t.vf;
        if (k < 0) begin
            e = '{x: ht - 1, y: vt - 1, blank: 0, hs: 1, vs: 1, ls: 0, fs: 0, fc: 0};
        end else begin
            e.x     = k % ht;
            e.y     = (k / ht) % vt;
            e.blank = (e.x < t.hv && e.y < t.vv) ? 1 : 0;
            e.hs    = (e.x >= hs0 && e.x < hs0 + t.hsy) ? 0 : 1;
            e.vs    = (e.y >= vs0 && e.y < vs0 + t.vsy) ? 0 : 1;
            e.ls    = (e.x == 0) ? 1 : 0;
            e.fs    = (e.x == 0 && e.y == 0) ? 1 : 0;
            e.fc    = (k / (ht * vt) + 1) % 256;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input tim_t t, input int k,
                       input int x, input int y, input int bl, input int h, input int v,
                       input int hd, input int vd, input int bd,
                       input int ls, input int fs, input int fc);
        exp_t e, ed;
        e  = model(t, k);
        ed = model(t, k - t.d);
        chk({tag, ".DrawX"}, x, e.x);
        chk({tag, ".DrawY"}, y, e.y);
        chk({tag, ".blank"}, bl, e.blank);
        chk({tag, ".hs"}, h, e.hs);
        chk({tag, ".vs"}, v, e.vs);
        chk({tag, ".hs_d"}, hd, ed.hs);
        chk({tag, ".vs_d"}, vd, ed.vs);
        chk({tag, ".blank_d"}, bd, ed.blank);
        chk({tag, ".line_start"}, ls, e.ls);
        chk({tag, ".frame_start"}, fs, e.fs);
        chk({tag, ".frame_count"}, fc, e.fc);
    endtask

    always @(negedge clk) begin
        cmp("a", TA, k_a, int'(x_a), int'(y_a), int'(bl_a), int'(hs_a), int'(vs_a),
            int'(hsd_a), int'(vsd_a), int'(bld_a), int'(ls_a), int'(fs_a), int'(fc_a));
        cmp("b", TB, k_b, int'(x_b), int'(y_b), int'(bl_b), int'(hs_b), int'(vs_b),
            int'(hsd_b), int'(vsd_b), int'(bld_b), int'(ls_b), int'(fs_b), int'(fc_b));
    end

    initial begin
        int hs_low, hs_first, hs_last, bl_cnt, ls_cnt;
        int vs_low_b, bl_b_cnt, fs_b_cnt;
        bit found;
        hs_low = 0; hs_first = -1; hs_last = -1; bl_cnt = 0; ls_cnt = 0;
        vs_low_b = 0; bl_b_cnt = 0; fs_b_cnt = 0;

        // Reset held for 5 cycles
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst.DrawX", int'(x_a), 799);
        chk("rst.DrawY", int'(y_a), 524);
        chk("rst.hs_vs", int'({hs_a, vs_a}), 3);
        chk("rst.blank", int'(bl_a), 0);

        @(posedge clk); #3;
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("first.DrawXY", int'({x_a, y_a}), 0);
                chk("first.blank", int'(bl_a), 1);
                chk("first.frame_start", int'(fs_a), 1);
                chk("first.frame_count", int'(fc_a), 1);
                chk("first.blank_d", int'(bld_a), 0);
            end
            if (i == 2)   chk("lit.blank_d@2", int'(bld_a), 1);
            if (i == 655) chk("lit.hs@655", int'(hs_a), 1);
            if (i == 656) chk("lit.hs@656", int'(hs_a), 0);
            if (!hs_a) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
            if (bl_a) bl_cnt++;
            if (ls_a) ls_cnt++;
            if (i < B_FRAME) begin
                if (!vs_b) vs_low_b++;
                if (bl_b) bl_b_cnt++;
                if (fs_b) fs_b_cnt++;
            end
        end
        chk("line.hs_low_cycles", hs_low, 96);
        chk("line.hs_first_x", hs_first, 656);
        chk("line.hs_last_x", hs_last, 751);
        chk("line.blank_cycles", bl_cnt, 640);
        chk("line.line_starts", ls_cnt, 1);
        chk("frame_b.vs_low_cycles", vs_low_b, 32);
        chk("frame_b.blank_cycles", bl_b_cnt, 48);
        chk("frame_b.frame_starts", fs_b_cnt, 1);

        // Mid-line asynchronous reset on the full-size instance
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (x_a == 10'd300) found = 1;
        end
        chk("midrst.reached_x300", int'(found), 1);
        #2 rst_a = 1'b0;
        #1;
        chk("midrst.DrawX", int'(x_a), 799);
        chk("midrst.DrawY", int'(y_a), 524);
        chk("midrst.syncs", int'({hs_a, vs_a, bl_a, hsd_a, vsd_a, bld_a}), 6'b110110);
        chk("midrst.frame_count", int'(fc_a), 0);
        repeat (3) @(posedge clk);
        #3 rst_a = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("restart.DrawXY", int'({x_a, y_a}), 0);
        chk("restart.frame_count", int'(fc_a), 1);

        // Frame counter wrap on the small instance
        found = 0;
        for (int i = 0; i < 50000 && !found; i++) begin
            @(negedge clk);
            if (k_b == 255 * B_FRAME - 1) found = 1;
        end
        chk("wrap.reached", int'(found), 1);
        chk("wrap.pre_x", int'(x_b), 15);
        chk("wrap.pre_y", int'(y_b), 10);
        chk("wrap.pre_fc", int'(fc_b), 255);
        @(negedge clk);
        chk("wrap.post_xy", int'({x_b, y_b}), 0);
        chk("wrap.post_fc", int'(fc_b), 0);
        chk("wrap.post_fs", int'(fs_b), 1);

        // Randomly timed asynchronous resets on both instances
        repeat (8) begin
            bit hit_a;
            repeat ($urandom_range(1, 300)) @(negedge clk);
            hit_a = ($urandom_range(0, 1) == 1);
            #2;
            rst_b = 1'b0;
            if (hit_a) rst_a = 1'b0;
            #1;
            chk("rndrst.b_DrawX", int'(x_b), 15);
            chk("rndrst.b_fc", int'(fc_b), 0);
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #3 rst_a = 1'b1; rst_b = 1'b1;
        end
        repeat (400) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
